// File: rtl/ysyx_22041071_rd_arbiter_if.sv
// Bus bundle for the two-client read arbiter: IF/MEM request/response ports
// plus the single-beat AR/R channel toward the AXI read master.
interface ysyx_22041071_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_size;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic [1:0]        if_rsp_resp;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [1:0]        mem_rsp_resp;

  logic              dn_ar_valid;
  logic              dn_ar_ready;
  logic [ID_W-1:0]   dn_id;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_len;
  logic [1:0]        dn_size;
  logic              dn_r_valid;
  logic [DATA_W-1:0] dn_r_data;
  logic [1:0]        dn_r_resp;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr, if_size,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp,
    input  mem_req_valid, mem_addr, mem_size,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp,
    output dn_ar_valid, dn_id, dn_addr, dn_len, dn_size,
    input  dn_ar_ready, dn_r_valid, dn_r_data, dn_r_resp
  );

  // Client / read-master side
  modport master (
    output if_req_valid, if_addr, if_size,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp,
    output mem_req_valid, mem_addr, mem_size,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp,
    input  dn_ar_valid, dn_id, dn_addr, dn_len, dn_size,
    output dn_ar_ready, dn_r_valid, dn_r_data, dn_r_resp
  );
endinterface

// File: rtl/ysyx_22041071_rd_arbiter.sv
// Two-client (IF/MEM) single-beat read arbiter in front of the AXI read master.
// Define YSYX_22041071_ARB_RR_EN for round-robin; default is fixed MEM-over-IF priority.
module ysyx_22041071_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int IF_ID  = 0,
  parameter int MEM_ID = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ysyx_22041071_rd_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [1:0]        if_resp_q, if_resp_d;
  logic [1:0]        mem_resp_q, mem_resp_d;
  logic              gnt_if, gnt_mem;
  logic [DATA_W-1:0] rdata_fmt;

  // Right-align the addressed bytes and zero everything above the access size.
  function automatic logic [DATA_W-1:0] align_rdata(input logic [DATA_W-1:0] data,
                                                    input logic [2:0]        off,
                                                    input logic [1:0]        size);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    shifted = data >> {off, 3'b000};
    case (size)
      2'b00:   mask = DATA_W'(8'hFF);
      2'b01:   mask = DATA_W'(16'hFFFF);
      2'b10:   mask = DATA_W'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    return shifted & mask;
  endfunction

  assign rdata_fmt = align_rdata(bus.dn_r_data, addr_q[2:0], size_q);

`ifdef YSYX_22041071_ARB_RR_EN
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (reset_n && state_q == S_IDLE) begin
      if (bus.if_req_valid && bus.mem_req_valid) begin
        gnt_if  = (last_owner_q == OWN_MEM);
        gnt_mem = (last_owner_q == OWN_IF);
      end else begin
        gnt_if  = bus.if_req_valid;
        gnt_mem = bus.mem_req_valid;
      end
    end
  end
`else
  logic last_owner_unused;
  assign last_owner_unused = last_owner_q;

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (reset_n && state_q == S_IDLE) begin
      gnt_mem = bus.mem_req_valid;
      gnt_if  = bus.if_req_valid && !bus.mem_req_valid;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    size_d       = size_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    if_resp_d    = if_resp_q;
    mem_resp_d   = mem_resp_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_if || gnt_mem) begin
          owner_d = gnt_mem ? OWN_MEM : OWN_IF;
          addr_d  = gnt_mem ? bus.mem_addr : bus.if_addr;
          size_d  = gnt_mem ? bus.mem_size : bus.if_size;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.dn_ar_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Capture straight into the owner's output register so the other client's data holds.
        if (bus.dn_r_valid) begin
          state_d = S_RESP;
          if (owner_q == OWN_MEM) begin
            mem_data_d = rdata_fmt;
            mem_resp_d = bus.dn_r_resp;
          end else begin
            if_data_d = rdata_fmt;
            if_resp_d = bus.dn_r_resp;
          end
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        last_owner_d = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_MEM;
      addr_q       <= '0;
      size_q       <= '0;
      if_data_q    <= '0;
      mem_data_q   <= '0;
      if_resp_q    <= '0;
      mem_resp_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      if_data_q    <= if_data_d;
      mem_data_q   <= mem_data_d;
      if_resp_q    <= if_resp_d;
      mem_resp_q   <= mem_resp_d;
    end
  end

  assign bus.if_req_ready  = gnt_if;
  assign bus.mem_req_ready = gnt_mem;
  assign bus.if_rsp_valid  = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign bus.mem_rsp_valid = (state_q == S_RESP) && (owner_q == OWN_MEM);
  assign bus.if_rsp_data   = if_data_q;
  assign bus.mem_rsp_data  = mem_data_q;
  assign bus.if_rsp_resp   = if_resp_q;
  assign bus.mem_rsp_resp  = mem_resp_q;

  assign bus.dn_ar_valid = (state_q == S_REQ);
  assign bus.dn_id       = (owner_q == OWN_MEM) ? ID_W'(MEM_ID) : ID_W'(IF_ID);
  assign bus.dn_addr     = addr_q;
  assign bus.dn_len      = '0;
  assign bus.dn_size     = size_q;

endmodule

// File: tb/tb_ysyx_22041071_rd_arbiter.sv
// Bench for ysyx_22041071_rd_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ysyx_22041071_rd_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
`ifdef YSYX_22041071_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041071_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  ysyx_22041071_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .IF_ID(0), .MEM_ID(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.if_req_valid  = 1'b0;
    bus.if_addr       = '0;
    bus.if_size       = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_size      = '0;
    bus.dn_ar_ready   = 1'b0;
    bus.dn_r_valid    = 1'b0;
    bus.dn_r_data     = '0;
    bus.dn_r_resp     = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {bus.if_req_ready, bus.mem_req_ready, bus.if_rsp_valid,
                          bus.mem_rsp_valid, bus.dn_ar_valid}, 64'd0);
    check({tag, "_ifd"}, bus.if_rsp_data, 64'd0);
    check({tag, "_memd"}, bus.mem_rsp_data, 64'd0);
    check({tag, "_resp"}, {bus.if_rsp_resp, bus.mem_rsp_resp}, 64'd0);
    check({tag, "_id"}, bus.dn_id, 64'd0);
    check({tag, "_addr"}, bus.dn_addr, 64'd0);
    check({tag, "_lensz"}, {bus.dn_len, bus.dn_size}, 64'd0);
  endtask

  task automatic do_reset();
    drive_idle();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One isolated transaction for a single client, with optional AR back-pressure.
  task automatic run_one(input string tag, input bit is_mem, input logic [63:0] addr,
                         input logic [1:0] size, input logic [63:0] rdata,
                         input logic [1:0] rresp, input int stall,
                         input logic [63:0] exp_data);
    to_drive();
    if (is_mem) begin
      bus.mem_req_valid = 1'b1; bus.mem_addr = addr; bus.mem_size = size;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_addr = addr; bus.if_size = size;
    end
    to_sample();
    check({tag, "_accept"}, {bus.if_req_ready, bus.mem_req_ready}, is_mem ? 64'd1 : 64'd2);
    to_drive();
    bus.if_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
    bus.if_addr = ~addr; bus.mem_addr = ~addr; bus.if_size = ~size; bus.mem_size = ~size;
    for (int i = 0; i < stall; i++) begin
      bus.dn_ar_ready = 1'b0;
      if (is_mem) bus.if_req_valid = 1'b1;
      else        bus.mem_req_valid = 1'b1;
      to_sample();
      check({tag, "_stall_arv"}, bus.dn_ar_valid, 64'd1);
      check({tag, "_stall_addr"}, bus.dn_addr, addr);
      check({tag, "_stall_size"}, bus.dn_size, size);
      check({tag, "_stall_rdy"}, {bus.if_req_ready, bus.mem_req_ready}, 64'd0);
      to_drive();
    end
    bus.if_req_valid = 1'b0; bus.mem_req_valid = 1'b0; bus.dn_ar_ready = 1'b1;
    to_sample();
    check({tag, "_arv"}, bus.dn_ar_valid, 64'd1);
    check({tag, "_id"}, bus.dn_id, is_mem ? 64'd1 : 64'd0);
    check({tag, "_addr"}, bus.dn_addr, addr);
    check({tag, "_lensz"}, {bus.dn_len, bus.dn_size}, {54'd0, size});
    to_drive();
    bus.dn_ar_ready = 1'b0;
    bus.dn_r_valid = 1'b1; bus.dn_r_data = rdata; bus.dn_r_resp = rresp;
    to_sample();
    check({tag, "_wait"}, {bus.dn_ar_valid, bus.if_rsp_valid, bus.mem_rsp_valid}, 64'd0);
    to_drive();
    bus.dn_r_valid = 1'b0; bus.dn_r_data = '0; bus.dn_r_resp = '0;
    to_sample();
    check({tag, "_rspv"}, {bus.if_rsp_valid, bus.mem_rsp_valid}, is_mem ? 64'd1 : 64'd2);
    check({tag, "_data"}, is_mem ? bus.mem_rsp_data : bus.if_rsp_data, exp_data);
    check({tag, "_resp"}, is_mem ? bus.mem_rsp_resp : bus.if_rsp_resp, {62'd0, rresp});
    to_drive();
    to_sample();
    check({tag, "_pulse"}, {bus.if_rsp_valid, bus.mem_rsp_valid}, 64'd0);
  endtask

  // Bus word as the read master presents it: only the requested bytes survive, in place.
  function automatic logic [63:0] bus_word(input logic [63:0] w, input int off, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + n) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] client_word(input logic [63:0] w, input int off, input int n);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < n; b++) r[8*b +: 8] = w[8*(off+b) +: 8];
    return r;
  endfunction

  // Reference model state for the randomized run
  bit          pend[2];
  logic [63:0] p_addr[2];
  logic [1:0]  p_size[2];
  int          phase, own, last_own, win, dly;
  logic [63:0] cur_addr, word;
  logic [1:0]  cur_size, r_resp;

  initial begin
    int order[2];
    int nacc, nrsp;
    bit acc_if, acc_mem;

    drive_idle();
    bus.if_req_valid = 1'b1;
    bus.mem_req_valid = 1'b1;
    #12;
    check_outputs_zero("reset");
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;

    // Simultaneous requests straight out of reset
    to_drive();
    bus.if_req_valid = 1'b1; bus.if_addr = 64'h100; bus.if_size = 2'b11;
    bus.mem_req_valid = 1'b1; bus.mem_addr = 64'h200; bus.mem_size = 2'b11;
    bus.dn_ar_ready = 1'b1; bus.dn_r_valid = 1'b1;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      to_sample();
      acc_if  = bus.if_req_valid && bus.if_req_ready;
      acc_mem = bus.mem_req_valid && bus.mem_req_ready;
      if (acc_if && nacc < 2)  begin order[nacc] = 0; nacc++; end
      if (acc_mem && nacc < 2) begin order[nacc] = 1; nacc++; end
      to_drive();
      if (acc_if)  bus.if_req_valid = 1'b0;
      if (acc_mem) bus.mem_req_valid = 1'b0;
    end
    drive_idle();
    to_sample();
    check("tie_count", nacc, 2);
    check("tie_first", order[0], RR ? 64'd0 : 64'd1);
    check("tie_second", order[1], RR ? 64'd1 : 64'd0);

    run_one("if_word", 1'b0, 64'h8000_0004, 2'b10, 64'hDEADBEEF_0000_0000, 2'b00, 0, 64'hDEADBEEF);
    run_one("ar_stall", 1'b0, 64'h8000_1010, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b00, 5,
            64'h0123_4567_89AB_CDEF);
    run_one("mem_b7", 1'b1, 64'h8000_2007, 2'b00, 64'h8000_0000_0000_0000, 2'b10, 0, 64'h80);
    run_one("mem_half", 1'b1, 64'h8000_3002, 2'b01, 64'h0000_0000_BEEF_0000, 2'b01, 1, 64'hBEEF);

    // Reset while waiting for read data
    to_drive();
    bus.if_req_valid = 1'b1; bus.if_addr = 64'h8; bus.if_size = 2'b11;
    to_sample();
    to_drive();
    bus.if_req_valid = 1'b0; bus.dn_ar_ready = 1'b1;
    to_sample();
    to_drive();
    bus.dn_ar_ready = 1'b0;
    to_sample();
    check("rst_wait_arv", bus.dn_ar_valid, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    to_drive();
    bus.dn_r_valid = 1'b1; bus.dn_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      to_sample();
      check("rst_no_rsp", {bus.if_rsp_valid, bus.mem_rsp_valid}, 64'd0);
      to_drive();
    end
    drive_idle();
    to_sample();

    // Back-to-back IF requests with read data valid held high
    to_drive();
    bus.if_req_valid = 1'b1; bus.if_addr = 64'h40; bus.if_size = 2'b11;
    bus.dn_ar_ready = 1'b1; bus.dn_r_valid = 1'b1; bus.dn_r_data = 64'h55;
    nacc = 0; nrsp = 0;
    for (int c = 0; c < 38; c++) begin
      to_sample();
      if (bus.if_req_valid && bus.if_req_ready) nacc++;
      if (bus.if_rsp_valid) begin
        nrsp++;
        check("b2b_data", bus.if_rsp_data, 64'h55);
      end
      to_drive();
      if (c == 31) bus.if_req_valid = 1'b0;
    end
    drive_idle();
    to_sample();
    check("b2b_accepts", nacc, 8);
    check("b2b_rsps", nrsp, 8);

    // Randomized traffic against the reference model
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    phase = 0; own = 0; last_own = 1; dly = 0;
    cur_addr = '0; cur_size = '0; word = '0; r_resp = '0;
    for (int c = 0; c < 1500; c++) begin
      to_drive();
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          logic [63:0] a;
          pend[k]   = 1'b1;
          p_size[k] = 2'($urandom_range(0, 3));
          a = {$urandom(), $urandom()};
          p_addr[k] = a & ~((64'd1 << p_size[k]) - 64'd1);
        end
      end
      bus.if_req_valid  = pend[0];
      bus.if_addr       = pend[0] ? p_addr[0] : {$urandom(), $urandom()};
      bus.if_size       = pend[0] ? p_size[0] : 2'($urandom_range(0, 3));
      bus.mem_req_valid = pend[1];
      bus.mem_addr      = pend[1] ? p_addr[1] : {$urandom(), $urandom()};
      bus.mem_size      = pend[1] ? p_size[1] : 2'($urandom_range(0, 3));
      bus.dn_ar_ready   = 1'($urandom_range(0, 1));
      if (phase == 2 && dly == 0) begin
        bus.dn_r_valid = 1'b1;
        bus.dn_r_data  = bus_word(word, int'(cur_addr[2:0]), 1 << cur_size);
        bus.dn_r_resp  = r_resp;
      end else begin
        bus.dn_r_valid = 1'b0;
        bus.dn_r_data  = {$urandom(), $urandom()};
        bus.dn_r_resp  = 2'($urandom_range(0, 3));
      end

      to_sample();
      win = -1;
      if (phase == 0) begin
        if (pend[0] && pend[1]) win = RR ? (last_own == 1 ? 0 : 1) : 1;
        else if (pend[1])       win = 1;
        else if (pend[0])       win = 0;
      end
      check("rnd_ready", {bus.if_req_ready, bus.mem_req_ready},
            {62'd0, win == 0, win == 1});
      check("rnd_arvalid", bus.dn_ar_valid, {63'd0, phase == 1});
      check("rnd_rspvalid", {bus.if_rsp_valid, bus.mem_rsp_valid},
            {62'd0, phase == 3 && own == 0, phase == 3 && own == 1});
      if (phase == 1) begin
        check("rnd_id", bus.dn_id, own);
        check("rnd_addr", bus.dn_addr, cur_addr);
        check("rnd_size", bus.dn_size, cur_size);
      end
      if (phase == 3) begin
        check("rnd_data", own == 1 ? bus.mem_rsp_data : bus.if_rsp_data,
              client_word(word, int'(cur_addr[2:0]), 1 << cur_size));
        check("rnd_resp", own == 1 ? bus.mem_rsp_resp : bus.if_rsp_resp, r_resp);
      end

      case (phase)
        0: if (win >= 0) begin
          own = win; cur_addr = p_addr[win]; cur_size = p_size[win];
          pend[win] = 1'b0; phase = 1;
        end
        1: if (bus.dn_ar_ready) begin
          phase = 2; dly = $urandom_range(0, 3);
          word = {$urandom(), $urandom()}; r_resp = 2'($urandom_range(0, 3));
        end
        2: if (bus.dn_r_valid) phase = 3; else dly--;
        default: begin phase = 0; last_own = own; end
      endcase
    end
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
